// File: rtl/operand_stage.sv
// ID/EX operand stage: captures register-file read data and forwards EX/WB results.
// It stalls on load-use hazards and issues operands to EX over a valid/ready handshake.
// Define OPERAND_STAGE_PERF_EN to add saturating stall/forward performance counters.
module operand_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RADDR-1:0] rs1,
  input  logic [RADDR-1:0] rs2,
  input  logic [XLEN-1:0]  rd1,
  input  logic [XLEN-1:0]  rd2,
  input  logic [RADDR-1:0] rd,
  input  logic [XLEN-1:0]  imm,
  input  logic             use_imm,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [RADDR-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [XLEN-1:0]  ex_result,
  input  logic [RADDR-1:0] wb_rd,
  input  logic             wb_we,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  op_a,
  output logic [XLEN-1:0]  op_b,
  output logic [XLEN-1:0]  store_data,
  output logic [RADDR-1:0] out_rd,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write
`ifdef OPERAND_STAGE_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      fwd_ex_cnt,
  output logic [31:0]      fwd_wb_cnt
`endif
);

  localparam logic [RADDR-1:0] REG_ZERO  = {RADDR{1'b0}};
  localparam logic [XLEN-1:0]  DATA_ZERO = {XLEN{1'b0}};

  function automatic logic [XLEN-1:0] pick_operand(
    input logic            is_x0,
    input logic            ex_hit,
    input logic            wb_hit,
    input logic [XLEN-1:0] ex_val,
    input logic [XLEN-1:0] wb_val,
    input logic [XLEN-1:0] rf_val
  );
    logic [XLEN-1:0] res;
    if (is_x0) begin
      res = DATA_ZERO;
    end else if (ex_hit) begin
      res = ex_val;
    end else if (wb_hit) begin
      res = wb_val;
    end else begin
      res = rf_val;
    end
    return res;
  endfunction

  logic             ex_fwd_ok;
  logic             rs1_x0, rs2_x0;
  logic             rs1_ex_hit, rs2_ex_hit;
  logic             rs1_wb_hit, rs2_wb_hit;
  logic             rs2_used;
  logic             hazard;
  logic             advance;
  logic [XLEN-1:0]  rs1_val, rs2_val;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  op_a_q, op_a_d;
  logic [XLEN-1:0]  op_b_q, op_b_d;
  logic [XLEN-1:0]  store_data_q, store_data_d;
  logic [RADDR-1:0] out_rd_q, out_rd_d;
  logic             out_reg_write_q, out_reg_write_d;
  logic             out_mem_read_q, out_mem_read_d;
  logic             out_mem_write_q, out_mem_write_d;

  // Forwarding hit detection, operand selection and load-use hazard; EX beats WB, x0 beats both.
  always_comb begin
    ex_fwd_ok  = ex_reg_write && !ex_mem_read;
    rs1_x0     = (rs1 == REG_ZERO);
    rs2_x0     = (rs2 == REG_ZERO);
    rs1_ex_hit = !rs1_x0 && ex_fwd_ok && (ex_rd == rs1);
    rs2_ex_hit = !rs2_x0 && ex_fwd_ok && (ex_rd == rs2);
    rs1_wb_hit = !rs1_x0 && !rs1_ex_hit && wb_we && (wb_rd == rs1);
    rs2_wb_hit = !rs2_x0 && !rs2_ex_hit && wb_we && (wb_rd == rs2);
    rs1_val    = pick_operand(rs1_x0, rs1_ex_hit, rs1_wb_hit, ex_result, wb_data, rd1);
    rs2_val    = pick_operand(rs2_x0, rs2_ex_hit, rs2_wb_hit, ex_result, wb_data, rd2);
    rs2_used   = !use_imm || mem_write;
    hazard     = in_valid && ex_mem_read && (ex_rd != REG_ZERO) &&
                 ((ex_rd == rs1) || ((ex_rd == rs2) && rs2_used));
    advance    = !out_valid_q || out_ready;
    in_ready   = flush || (advance && !hazard);
  end

  // Next-state selection for the issue register; control bits are cleared whenever nothing issues.
  always_comb begin
    out_valid_d     = out_valid_q;
    op_a_d          = op_a_q;
    op_b_d          = op_b_q;
    store_data_d    = store_data_q;
    out_rd_d        = out_rd_q;
    out_reg_write_d = out_reg_write_q;
    out_mem_read_d  = out_mem_read_q;
    out_mem_write_d = out_mem_write_q;
    if (flush || (advance && hazard) || (advance && !in_valid)) begin
      out_valid_d     = 1'b0;
      out_reg_write_d = 1'b0;
      out_mem_read_d  = 1'b0;
      out_mem_write_d = 1'b0;
    end else if (advance) begin
      out_valid_d     = 1'b1;
      op_a_d          = rs1_val;
      op_b_d          = use_imm ? imm : rs2_val;
      store_data_d    = rs2_val;
      out_rd_d        = rd;
      out_reg_write_d = reg_write;
      out_mem_read_d  = mem_read;
      out_mem_write_d = mem_write;
    end else begin
      out_valid_d     = out_valid_q;
    end
  end

  // Issue register toward EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      op_a_q          <= DATA_ZERO;
      op_b_q          <= DATA_ZERO;
      store_data_q    <= DATA_ZERO;
      out_rd_q        <= REG_ZERO;
      out_reg_write_q <= 1'b0;
      out_mem_read_q  <= 1'b0;
      out_mem_write_q <= 1'b0;
    end else begin
      out_valid_q     <= out_valid_d;
      op_a_q          <= op_a_d;
      op_b_q          <= op_b_d;
      store_data_q    <= store_data_d;
      out_rd_q        <= out_rd_d;
      out_reg_write_q <= out_reg_write_d;
      out_mem_read_q  <= out_mem_read_d;
      out_mem_write_q <= out_mem_write_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign op_a          = op_a_q;
  assign op_b          = op_b_q;
  assign store_data    = store_data_q;
  assign out_rd        = out_rd_q;
  assign out_reg_write = out_reg_write_q;
  assign out_mem_read  = out_mem_read_q;
  assign out_mem_write = out_mem_write_q;

`ifdef OPERAND_STAGE_PERF_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic        accept;
  logic        uses_ex, uses_wb;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_ex_cnt_q, fwd_ex_cnt_d;
  logic [31:0] fwd_wb_cnt_q, fwd_wb_cnt_d;

  // Saturating event counters; forwards count once per issued instruction, rs2 only when it is read.
  always_comb begin
    accept  = !flush && advance && !hazard && in_valid;
    uses_ex = rs1_ex_hit || (rs2_used && rs2_ex_hit);
    uses_wb = rs1_wb_hit || (rs2_used && rs2_wb_hit);
    if (!flush && advance && hazard && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (accept && uses_ex && (fwd_ex_cnt_q != CNT_MAX)) begin
      fwd_ex_cnt_d = fwd_ex_cnt_q + 32'd1;
    end else begin
      fwd_ex_cnt_d = fwd_ex_cnt_q;
    end
    if (accept && uses_wb && (fwd_wb_cnt_q != CNT_MAX)) begin
      fwd_wb_cnt_d = fwd_wb_cnt_q + 32'd1;
    end else begin
      fwd_wb_cnt_d = fwd_wb_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= 32'd0;
      fwd_ex_cnt_q <= 32'd0;
      fwd_wb_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      fwd_ex_cnt_q <= fwd_ex_cnt_d;
      fwd_wb_cnt_q <= fwd_wb_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign fwd_ex_cnt = fwd_ex_cnt_q;
  assign fwd_wb_cnt = fwd_wb_cnt_q;
`endif

endmodule

// File: tb/tb_operand_stage.sv
// Scoreboard bench for operand_stage: directed test-plan cases, then randomized traffic
// against a transaction-level model of the stage (one outstanding slot, flush/stall rules).
module tb_operand_stage;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  rs1, rs2, rd, ex_rd, wb_rd, out_rd;
  logic [31:0] rd1, rd2, imm, ex_result, wb_data;
  logic        use_imm, reg_write, mem_read, mem_write;
  logic        ex_reg_write, ex_mem_read, wb_we, flush;
  logic        out_valid, out_ready;
  logic [31:0] op_a, op_b, store_data;
  logic        out_reg_write, out_mem_read, out_mem_write;
`ifdef OPERAND_STAGE_PERF_EN
  logic [31:0] stall_cnt, fwd_ex_cnt, fwd_wb_cnt;
`endif

  operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2), .rd(rd), .imm(imm), .use_imm(use_imm),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_result(ex_result), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b), .store_data(store_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write)
`ifdef OPERAND_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .fwd_ex_cnt(fwd_ex_cnt), .fwd_wb_cnt(fwd_wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  item_t       exp_q[$];
  logic        m_bubble = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] m_stall = 32'd0, m_fex = 32'd0, m_fwb = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference operand value: x0, then EX result (non-load), then WB data, then register file.
  function automatic logic [31:0] resolve(input logic [4:0] rs, input logic [31:0] rf,
                                          output int src);
    if (rs == 5'd0) begin src = 0; return 32'd0; end
    if (ex_reg_write && !ex_mem_read && ex_rd == rs) begin src = 1; return ex_result; end
    if (wb_we && wb_rd == rs) begin src = 2; return wb_data; end
    src = 3;
    return rf;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Decide what the stage does at the coming edge, given inputs held stable this cycle.
  task automatic model_step();
    logic adv, haz, exp_rdy, r2use;
    int s1, s2;
    item_t it;
    adv     = (exp_q.size() == 0) || out_ready;
    r2use   = !use_imm || mem_write;
    haz     = in_valid && ex_mem_read && ex_rd != 5'd0 &&
              (ex_rd == rs1 || (ex_rd == rs2 && r2use));
    exp_rdy = flush || (adv && !haz);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (exp_q.size() != 0 && (out_ready || flush)) exp_q.delete(0);
    m_bubble = 1'b0;
    if (flush) begin
      m_bubble = 1'b0;
    end else if (adv && haz) begin
      m_bubble = 1'b1;
      m_stall  = sat_inc(m_stall);
    end else if (adv && in_valid) begin
      it.a  = resolve(rs1, rd1, s1);
      it.sd = resolve(rs2, rd2, s2);
      it.b  = use_imm ? imm : it.sd;
      it.rd = rd;
      it.rw = reg_write;
      it.mr = mem_read;
      it.mw = mem_write;
      exp_q.push_back(it);
      if (s1 == 1 || (r2use && s2 == 1)) m_fex = sat_inc(m_fex);
      if (s1 == 2 || (r2use && s2 == 2)) m_fwb = sat_inc(m_fwb);
    end
    hold = in_valid && !exp_rdy;
  endtask

  // Monitor: compare the presented output against the scoreboard head every cycle.
  always @(negedge clk) begin
    check("out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() != 0)});
    if (out_valid && exp_q.size() != 0) begin
      check("op_a", op_a, exp_q[0].a);
      check("op_b", op_b, exp_q[0].b);
      check("store_data", store_data, exp_q[0].sd);
      check("out_rd", {27'd0, out_rd}, {27'd0, exp_q[0].rd});
      check("ctrl", {29'd0, out_reg_write, out_mem_read, out_mem_write},
            {29'd0, exp_q[0].rw, exp_q[0].mr, exp_q[0].mw});
    end
    if (m_bubble) begin
      check("bubble_ctrl", {29'd0, out_reg_write, out_mem_read, out_mem_write}, 32'd0);
    end
`ifdef OPERAND_STAGE_PERF_EN
    check("stall_cnt", stall_cnt, m_stall);
    check("fwd_ex_cnt", fwd_ex_cnt, m_fex);
    check("fwd_wb_cnt", fwd_wb_cnt, m_fwb);
`endif
  end

  task automatic step();
    #4;
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] rdst,
                     input logic [31:0] im, input logic ui, input logic rw, input logic mr,
                     input logic mw);
    in_valid = v; rs1 = r1; rs2 = r2; rd1 = d1; rd2 = d2; rd = rdst;
    imm = im; use_imm = ui; reg_write = rw; mem_read = mr; mem_write = mw;
  endtask

  task automatic fwd(input logic [4:0] erd, input logic erw, input logic emr,
                     input logic [31:0] eres, input logic [4:0] wrd, input logic wwe,
                     input logic [31:0] wd);
    ex_rd = erd; ex_reg_write = erw; ex_mem_read = emr; ex_result = eres;
    wb_rd = wrd; wb_we = wwe; wb_data = wd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    m_bubble = 1'b0;
    hold = 1'b0;
    m_stall = 32'd0; m_fex = 32'd0; m_fwb = 32'd0;
    in_valid = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_op_a", op_a, 32'd0);
    check("rst_op_b", op_b, 32'd0);
    check("rst_store_data", store_data, 32'd0);
    check("rst_out_rd", {27'd0, out_rd}, 32'd0);
    check("rst_ctrl", {29'd0, out_reg_write, out_mem_read, out_mem_write}, 32'd0);
`ifdef OPERAND_STAGE_PERF_EN
    check("rst_cnt", stall_cnt | fwd_ex_cnt | fwd_wb_cnt, 32'd0);
`endif
    rst_n = 1'b1;
  endtask

  task automatic rand_cycle();
    if (!hold) begin
      drv(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          $urandom, $urandom, 5'($urandom_range(0, 7)), $urandom, 1'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
    end
    fwd(5'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 3) == 0), $urandom,
        5'($urandom_range(0, 7)), 1'($urandom), $urandom);
    flush     = ($urandom_range(0, 15) == 0);
    out_ready = ($urandom_range(0, 3) != 0);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    drv(1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    fwd(5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    flush = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #2;
    do_reset();

    // Basic issue, no forwarding.
    drv(1'b1, 5'd1, 5'd2, 32'h11, 32'h22, 5'd5, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("tp_basic_op_a", op_a, 32'h11);
    check("tp_basic_op_b", op_b, 32'h22);
    // EX beats WB, then WB alone.
    drv(1'b1, 5'd3, 5'd2, 32'h33, 32'h22, 5'd6, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0);
    fwd(5'd3, 1'b1, 1'b0, 32'hAAAA, 5'd3, 1'b1, 32'hBBBB);
    step();
    check("tp_ex_prio", op_a, 32'hAAAA);
    fwd(5'd3, 1'b0, 1'b0, 32'hAAAA, 5'd3, 1'b1, 32'hBBBB);
    step();
    check("tp_wb_fwd", op_a, 32'hBBBB);
    // x0 is never forwarded.
    drv(1'b1, 5'd0, 5'd2, 32'h99, 32'h22, 5'd7, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    fwd(5'd0, 1'b1, 1'b0, 32'h5, 5'd0, 1'b1, 32'h6);
    step();
    check("tp_x0", op_a, 32'd0);
    // Load-use on rs2: one bubble, then issue with WB-forwarded value.
    drv(1'b1, 5'd1, 5'd4, 32'h11, 32'h44, 5'd8, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    fwd(5'd4, 1'b1, 1'b1, 32'h0, 5'd0, 1'b0, 32'd0);
    step();
    check("tp_bubble_valid", {31'd0, out_valid}, 32'd0);
    check("tp_bubble_rw", {31'd0, out_reg_write}, 32'd0);
    fwd(5'd0, 1'b0, 1'b0, 32'h0, 5'd4, 1'b1, 32'h77);
    step();
    check("tp_loaduse_op_b", op_b, 32'h77);
    // EX stall with flush in the second stalled cycle.
    fwd(5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'd0);
    drv(1'b1, 5'd1, 5'd2, 32'h1234, 32'h5678, 5'd9, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    out_ready = 1'b0;
    drv(1'b1, 5'd2, 5'd1, 32'hCAFE, 32'hF00D, 5'd10, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("tp_stall_hold", op_a, 32'h1234);
    flush = 1'b1;
    step();
    check("tp_flush_kill", {31'd0, out_valid}, 32'd0);
    flush = 1'b0;
    step();
    out_ready = 1'b1;
    in_valid = 1'b0;
    step();

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
      end
      rand_cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
